// File: rtl/cmd_pkg.sv
// Shared definitions for the command-frame decoder: state encodings,
// header defaults, frame byte positions and a byte-select helper.
package cmd_pkg;

  // 4-bit state codes, same width as the top-level state display
  localparam logic [3:0] ST_IDLE = 4'h0;
  localparam logic [3:0] ST_HEAD = 4'h1;
  localparam logic [3:0] ST_SUM  = 4'h2;
  localparam logic [3:0] ST_CHK  = 4'h3;
  localparam logic [3:0] ST_DONE = 4'h4;

  localparam logic [7:0] HEAD0_DEF = 8'h55;
  localparam logic [7:0] HEAD1_DEF = 8'hAA;

  localparam int NPAY_DEF  = 9;
  localparam int FRAME_LEN = 12;

  // Byte positions inside the 12-byte frame (byte 0 = first received)
  localparam logic [3:0] HDR0_IDX = 4'd0;
  localparam logic [3:0] HDR1_IDX = 4'd1;
  localparam logic [3:0] CMD_KDEV = 4'd2;
  localparam logic [3:0] CMD_SMPR = 4'd3;
  localparam logic [3:0] CMD_FILT = 4'd4;
  localparam logic [3:0] CMD_MIX0 = 4'd5;
  localparam logic [3:0] CMD_MIX1 = 4'd6;
  localparam logic [3:0] CMD_REG4 = 4'd7;
  localparam logic [3:0] CMD_REG5 = 4'd8;
  localparam logic [3:0] CMD_REG6 = 4'd9;
  localparam logic [3:0] CMD_REG7 = 4'd10;
  localparam logic [3:0] CSUM_IDX = 4'd11;

  // Byte k of a frame sits at f[95-8k -: 8]; shift it up to the top byte.
  function automatic logic [7:0] frame_byte(input logic [8*FRAME_LEN-1:0] f,
                                            input logic [3:0] k);
    logic [8*FRAME_LEN-1:0] sh;
    sh = f << {k, 3'b000};
    return sh[8*FRAME_LEN-1 -: 8];
  endfunction

endpackage

// File: rtl/cmd_decode.sv
// Command-frame decoder: latches a 96-bit frame, checks header and
// payload checksum, and commits nine command registers on a good frame.
//
// state | meaning
// IDLE  | wait for fs, latch frame, clear err
// HEAD  | compare bytes 0/1 against HEAD0/HEAD1
// SUM   | accumulate one payload byte per cycle (idx 0..NPAY-1)
// CHK   | compare sum with checksum byte, commit or flag err
// DONE  | fd high, wait for fs low
module cmd_decode
  import cmd_pkg::*;
#(
  parameter logic [7:0] HEAD0 = HEAD0_DEF,
  parameter logic [7:0] HEAD1 = HEAD1_DEF,
  parameter int         NPAY  = NPAY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [95:0] dat,
  output logic [7:0]  cmd_kdev,
  output logic [7:0]  cmd_smpr,
  output logic [7:0]  cmd_filt,
  output logic [7:0]  cmd_mix0,
  output logic [7:0]  cmd_mix1,
  output logic [7:0]  cmd_reg4,
  output logic [7:0]  cmd_reg5,
  output logic [7:0]  cmd_reg6,
  output logic [7:0]  cmd_reg7,
  output logic        err,
  output logic [7:0]  ok_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(NPAY - 1);

  logic [3:0]  state_q, state_d;
  logic [95:0] buf_q, buf_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;
  logic [7:0]  ok_cnt_q, ok_cnt_d;
  // command registers indexed by their frame byte position
  logic [7:0]  cmd_q [CMD_KDEV:CMD_REG7];
  logic [7:0]  cmd_d [CMD_KDEV:CMD_REG7];

  // Next-state and datapath decode for the frame sequencer
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    err_d    = err_q;
    ok_cnt_d = ok_cnt_q;
    cmd_d    = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (fs) begin
          buf_d   = dat;
          err_d   = 1'b0;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (frame_byte(buf_q, HDR0_IDX) != HEAD0 ||
            frame_byte(buf_q, HDR1_IDX) != HEAD1) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = 4'd0;
          sum_d   = 8'd0;
          state_d = ST_SUM;
        end
      end
      ST_SUM: begin
        // carry out of the 8-bit add is dropped: checksum is mod 256
        sum_d = sum_q + frame_byte(buf_q, idx_q + CMD_KDEV);
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (sum_q == frame_byte(buf_q, CSUM_IDX)) begin
          for (int k = CMD_KDEV; k <= CMD_REG7; k++) begin
            cmd_d[k] = frame_byte(buf_q, 4'(k));
          end
          ok_cnt_d = ok_cnt_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // fs must drop before another frame can start
        if (!fs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
      ok_cnt_q <= '0;
      cmd_q    <= '{default: 8'h00};
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
      ok_cnt_q <= ok_cnt_d;
      cmd_q    <= cmd_d;
    end
  end

  assign fd       = (state_q == ST_DONE);
  assign err      = err_q;
  assign ok_cnt   = ok_cnt_q;
  assign cmd_kdev = cmd_q[CMD_KDEV];
  assign cmd_smpr = cmd_q[CMD_SMPR];
  assign cmd_filt = cmd_q[CMD_FILT];
  assign cmd_mix0 = cmd_q[CMD_MIX0];
  assign cmd_mix1 = cmd_q[CMD_MIX1];
  assign cmd_reg4 = cmd_q[CMD_REG4];
  assign cmd_reg5 = cmd_q[CMD_REG5];
  assign cmd_reg6 = cmd_q[CMD_REG6];
  assign cmd_reg7 = cmd_q[CMD_REG7];

endmodule

// File: tb/tb_cmd_decode.sv
// Testbench for cmd_decode: fixed and random frames checked against a
// frame-level reference model (header/checksum rules, commit latency).
module tb_cmd_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic [95:0] dat;
  logic        fd;
  logic        err;
  logic [7:0]  ok_cnt;
  logic [7:0]  cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1;
  logic [7:0]  cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
  logic [7:0]  dut_cmd [9];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0] m_cmd [9];
  int         m_ok;

  always #5 clk = ~clk;

  cmd_decode dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .dat(dat),
    .cmd_kdev(cmd_kdev), .cmd_smpr(cmd_smpr), .cmd_filt(cmd_filt),
    .cmd_mix0(cmd_mix0), .cmd_mix1(cmd_mix1), .cmd_reg4(cmd_reg4),
    .cmd_reg5(cmd_reg5), .cmd_reg6(cmd_reg6), .cmd_reg7(cmd_reg7),
    .err(err), .ok_cnt(ok_cnt)
  );

  assign dut_cmd[0] = cmd_kdev;
  assign dut_cmd[1] = cmd_smpr;
  assign dut_cmd[2] = cmd_filt;
  assign dut_cmd[3] = cmd_mix0;
  assign dut_cmd[4] = cmd_mix1;
  assign dut_cmd[5] = cmd_reg4;
  assign dut_cmd[6] = cmd_reg5;
  assign dut_cmd[7] = cmd_reg6;
  assign dut_cmd[8] = cmd_reg7;

  function automatic logic [7:0] byte_of(input logic [95:0] f, input int k);
    logic [95:0] t;
    t = f >> (8 * (11 - k));
    return t[7:0];
  endfunction

  function automatic logic [95:0] good_frame(input logic [71:0] pay);
    int s;
    logic [71:0] t;
    s = 0;
    t = pay;
    for (int k = 0; k < 9; k++) begin
      s = s + int'(t[7:0]);
      t = t >> 8;
    end
    return {8'h55, 8'hAA, pay, 8'(s % 256)};
  endfunction

  function automatic logic [71:0] rand_pay();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  // Frame-level model: decides accept/reject and expected fd latency.
  task automatic model_frame(input logic [95:0] f, output bit e_err, output int e_lat);
    int s;
    s = 0;
    if (byte_of(f, 0) != 8'h55 || byte_of(f, 1) != 8'hAA) begin
      e_err = 1'b1;
      e_lat = 2;
      return;
    end
    for (int k = 2; k <= 10; k++) s = s + int'(byte_of(f, k));
    e_lat = 12;
    if (8'(s % 256) != byte_of(f, 11)) begin
      e_err = 1'b1;
    end else begin
      e_err = 1'b0;
      for (int k = 0; k < 9; k++) m_cmd[k] = byte_of(f, k + 2);
      m_ok = (m_ok + 1) % 256;
    end
  endtask

  // Raise fs with a frame, scramble dat after the latch edge, and return
  // the number of edges until fd (-1 if it never arrives).
  task automatic send_frame(input logic [95:0] f, input int drop_at, output int lat);
    @(negedge clk);
    dat = f;
    fs  = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      dat = {$urandom, $urandom, $urandom};
      if (c == drop_at) fs = 1'b0;
      if (fd) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic end_frame();
    fs = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if (fd !== 1'b0 || err !== 1'b0 || ok_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: fd=%b err=%b ok_cnt=%0d, want 0 0 0", fd, err, ok_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (dut_cmd[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_cmd[%0d]: got %h want 00", i, dut_cmd[i]);
      end
    end
  endtask

  // Directed frames: valid, bad header, bad checksum, checksum overflow.
  task automatic test_fixed_frames();
    logic [95:0] tbl [4];
    bit e_err;
    int e_lat, lat;
    tbl[0] = 96'h55AA_0102_0304_0506_0708_092D;
    tbl[1] = 96'h54AA_0102_0304_0506_0708_092D;
    tbl[2] = 96'h55AA_0102_0304_0506_0708_092E;
    tbl[3] = 96'h55AA_FFFF_FFFF_FFFF_FFFF_FFF7;
    for (int n = 0; n < 4; n++) begin
      model_frame(tbl[n], e_err, e_lat);
      send_frame(tbl[n], 0, lat);
      vectors++;
      if (lat !== e_lat) begin
        miscompares++;
        $display("FAIL fixed%0d_latency: got %0d want %0d", n, lat, e_lat);
      end
      vectors++;
      if (err !== e_err || ok_cnt !== 8'(m_ok)) begin
        miscompares++;
        $display("FAIL fixed%0d_status: err=%b ok_cnt=%0d want err=%b ok_cnt=%0d",
                 n, err, ok_cnt, e_err, m_ok);
      end
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (dut_cmd[i] !== m_cmd[i]) begin
          miscompares++;
          $display("FAIL fixed%0d_cmd[%0d]: got %h want %h", n, i, dut_cmd[i], m_cmd[i]);
        end
      end
      end_frame();
      vectors++;
      if (fd !== 1'b0) begin
        miscompares++;
        $display("FAIL fixed%0d_fd_release: got %b want 0", n, fd);
      end
    end
  endtask

  task automatic test_fs_withdraw();
    logic [95:0] f;
    bit e_err;
    int e_lat, lat, ok_before;
    f = good_frame(rand_pay());
    model_frame(f, e_err, e_lat);
    send_frame(f, 3, lat);
    vectors++;
    if (lat !== e_lat || err !== e_err || ok_cnt !== 8'(m_ok)) begin
      miscompares++;
      $display("FAIL withdraw_commit: lat=%0d err=%b ok=%0d want %0d %b %0d",
               lat, err, ok_cnt, e_lat, e_err, m_ok);
    end
    ok_before = m_ok;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (fd !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_fd_pulse: fd=%b one cycle after DONE, want 0", fd);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (fd !== 1'b0 || ok_cnt !== 8'(ok_before)) begin
      miscompares++;
      $display("FAIL withdraw_idle: fd=%b ok=%0d want 0 %0d", fd, ok_cnt, ok_before);
    end
  endtask

  task automatic test_fs_held();
    logic [95:0] f;
    bit e_err;
    int e_lat, lat, held;
    f = good_frame(rand_pay());
    model_frame(f, e_err, e_lat);
    send_frame(f, 0, lat);
    held = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      dat = good_frame(rand_pay());
      if (fd) held++;
    end
    vectors++;
    if (lat !== e_lat || held !== 40 || ok_cnt !== 8'(m_ok)) begin
      miscompares++;
      $display("FAIL held_single_commit: lat=%0d fd_cycles=%0d ok=%0d want %0d 40 %0d",
               lat, held, ok_cnt, e_lat, m_ok);
    end
    end_frame();
    f = good_frame(rand_pay());
    model_frame(f, e_err, e_lat);
    send_frame(f, 0, lat);
    vectors++;
    if (lat !== e_lat || ok_cnt !== 8'(m_ok) || dut_cmd[0] !== m_cmd[0] ||
        dut_cmd[8] !== m_cmd[8]) begin
      miscompares++;
      $display("FAIL held_second_commit: lat=%0d ok=%0d kdev=%h reg7=%h want %0d %0d %h %h",
               lat, ok_cnt, dut_cmd[0], dut_cmd[8], e_lat, m_ok, m_cmd[0], m_cmd[8]);
    end
    end_frame();
  endtask

  task automatic test_rst_mid_frame();
    logic [95:0] f;
    bit e_err;
    int e_lat, lat;
    f = good_frame(rand_pay());
    @(negedge clk);
    dat = f;
    fs  = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    fs  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ok = 0;
    for (int i = 0; i < 9; i++) m_cmd[i] = 8'h00;
    vectors++;
    if (fd !== 1'b0 || err !== 1'b0 || ok_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: fd=%b err=%b ok=%0d want 0 0 0", fd, err, ok_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (dut_cmd[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL rst_mid_cmd[%0d]: got %h want 00", i, dut_cmd[i]);
      end
    end
    f = good_frame(rand_pay());
    model_frame(f, e_err, e_lat);
    send_frame(f, 0, lat);
    vectors++;
    if (lat !== e_lat || err !== e_err || ok_cnt !== 8'(m_ok) || dut_cmd[4] !== m_cmd[4]) begin
      miscompares++;
      $display("FAIL rst_mid_recommit: lat=%0d err=%b ok=%0d mix1=%h want %0d %b %0d %h",
               lat, err, ok_cnt, dut_cmd[4], e_lat, e_err, m_ok, m_cmd[4]);
    end
    end_frame();
  endtask

  // Random mix of good, header-corrupted and checksum-corrupted frames,
  // with fs optionally withdrawn early.
  task automatic test_random();
    logic [95:0] f;
    bit e_err;
    int e_lat, lat, mode, drop;
    for (int n = 0; n < 40; n++) begin
      f = good_frame(rand_pay());
      mode = int'($urandom_range(0, 2));
      if (mode == 1) f[95:88] = f[95:88] ^ 8'($urandom_range(1, 255));
      if (mode == 2) f[7:0] = f[7:0] + 8'($urandom_range(1, 255));
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 11)) : 0;
      model_frame(f, e_err, e_lat);
      send_frame(f, drop, lat);
      vectors++;
      if (lat !== e_lat || err !== e_err || ok_cnt !== 8'(m_ok)) begin
        miscompares++;
        $display("FAIL random%0d_status: lat=%0d err=%b ok=%0d want %0d %b %0d",
                 n, lat, err, ok_cnt, e_lat, e_err, m_ok);
      end
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (dut_cmd[i] !== m_cmd[i]) begin
          miscompares++;
          $display("FAIL random%0d_cmd[%0d]: got %h want %h", n, i, dut_cmd[i], m_cmd[i]);
        end
      end
      if (fs) end_frame();
      else begin
        @(posedge clk);
        @(negedge clk);
      end
      vectors++;
      if (fd !== 1'b0) begin
        miscompares++;
        $display("FAIL random%0d_fd_release: got %b want 0", n, fd);
      end
    end
  endtask

  task automatic test_wrap();
    logic [95:0] f;
    bit e_err;
    int e_lat, lat, bad_lat;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ok = 0;
    for (int i = 0; i < 9; i++) m_cmd[i] = 8'h00;
    bad_lat = 0;
    for (int n = 0; n < 256; n++) begin
      f = good_frame(rand_pay());
      model_frame(f, e_err, e_lat);
      send_frame(f, 0, lat);
      if (lat != e_lat) bad_lat++;
      end_frame();
    end
    vectors++;
    if (bad_lat !== 0 || ok_cnt !== 8'(m_ok)) begin
      miscompares++;
      $display("FAIL wrap_ok_cnt: ok=%0d late_frames=%0d want ok=%0d late_frames=0",
               ok_cnt, bad_lat, m_ok);
    end
  endtask

  initial begin
    rst  = 1'b1;
    fs   = 1'b0;
    dat  = '0;
    m_ok = 0;
    for (int i = 0; i < 9; i++) m_cmd[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_fixed_frames();
    test_fs_withdraw();
    test_fs_held();
    test_rst_mid_frame();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
